// File: rtl/card_table_if.sv
`default_nettype none
// ============================================================================
// Module      : card_table_if
// Description : cs/ack bus between the collector and the card table.
//               Signal suffixes are seen from the table (slave) side.
// Revision    : 1.0 - initial release
// ============================================================================
interface card_table_if #(
  parameter int DW = 64
);
  logic          cs_i;
  logic          wr_i;
  logic [31:0]   adr_i;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic          ack_o;

  modport master (
    output cs_i, wr_i, adr_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cs_i, wr_i, adr_i, dat_i,
    output dat_o, ack_o
  );
endinterface
`default_nettype wire

// File: rtl/card_table.sv
`default_nettype none
// ============================================================================
// Module      : card_table
// Description : Two-level card-marking table for the GC write barrier.
//               A mark sets one bit in a per-map card word and one bit in a
//               per-map summary word; the collector accesses both arrays over
//               a cs/ack bus and clears them with a hardware sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module card_table #(
  parameter int DW   = 64,
  parameter int MAPW = 6,
  parameter int AW   = 8,
  parameter int CS   = 5
) (
  input  wire logic            clk_i,
  input  wire logic            rst_ni,
  card_table_if.slave          bus,
  input  wire logic [MAPW-1:0] mapno_i,
  input  wire logic            stp_i,
  input  wire logic [31:0]     stp_adr_i,
  output logic                 stp_rdy_o,
  input  wire logic            clr_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o,
  output logic [31:0]          dirty_cnt_o
);

  localparam int C_LG  = $clog2(DW);
  localparam int C_BO  = $clog2(DW / 8);
  localparam int C_CIW = MAPW + AW;
  localparam int C_SIW = MAPW + AW - C_LG;
  localparam int C_CDEPTH = 1 << C_CIW;
  localparam int C_SDEPTH = 1 << C_SIW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_MARK = 2'd2,
    S_CLR  = 2'd3
  } state_t;

  // Storage: asynchronous read, synchronous write, never reset.
  logic [DW-1:0] r_cm [C_CDEPTH];
  logic [DW-1:0] r_sm [C_SDEPTH];

  state_t           r_state;
  logic             r_ack;
  logic [DW-1:0]    r_dat;
  logic             r_done;
  logic [31:0]      r_dirty;
  logic [C_CIW-1:0] r_cnt;
  logic [C_CIW-1:0] r_cidx;
  logic [C_SIW-1:0] r_sidx;
  logic [C_LG-1:0]  r_cb;
  logic [C_LG-1:0]  r_sb;
  logic             r_bus_sm;

  logic [C_CIW-1:0] w_mk_cidx;
  logic [C_SIW-1:0] w_mk_sidx;
  logic [C_LG-1:0]  w_mk_cb;
  logic [C_LG-1:0]  w_mk_sb;
  logic [C_CIW-1:0] w_bus_cidx;
  logic [C_SIW-1:0] w_bus_sidx;
  logic             w_bus_sm;
  logic             w_bus_req;
  logic             w_bus_wr;
  logic             w_mark_acc;
  logic [DW-1:0]    w_old_card;
  logic             w_old_bit;
  logic             w_unused_bits;

  logic             w_cm_we;
  logic [C_CIW-1:0] w_cm_wa;
  logic [DW-1:0]    w_cm_wd;
  logic             w_sm_we;
  logic [C_SIW-1:0] w_sm_wa;
  logic [DW-1:0]    w_sm_wd;

  // Address decode for marks and bus accesses.
  assign w_mk_cidx  = {mapno_i, stp_adr_i[CS+C_LG+AW-1 : CS+C_LG]};
  assign w_mk_cb    = stp_adr_i[CS+C_LG-1 : CS];
  assign w_mk_sb    = stp_adr_i[CS+2*C_LG-1 : CS+C_LG];
  assign w_bus_cidx = {mapno_i, bus.adr_i[AW+C_BO-1 : C_BO]};
  assign w_bus_sm   = bus.adr_i[AW+C_BO];

  // When AW equals LG the summary has exactly one word per map.
  if (AW > C_LG) begin : g_sidx_sub
    assign w_mk_sidx  = {mapno_i, stp_adr_i[CS+C_LG+AW-1 : CS+2*C_LG]};
    assign w_bus_sidx = {mapno_i, bus.adr_i[AW-C_LG+C_BO-1 : C_BO]};
  end else begin : g_sidx_map
    assign w_mk_sidx  = mapno_i;
    assign w_bus_sidx = mapno_i;
  end

  // Address bits outside the decoded fields are don't-care.
  assign w_unused_bits = ^{bus.adr_i[31:AW+C_BO+1], bus.adr_i[C_BO-1:0],
                           stp_adr_i[31:CS+C_LG+AW], stp_adr_i[CS-1:0]};

  // A request seen while ack_o is still high is the tail of the previous one.
  assign w_bus_req  = (r_state == S_IDLE) && !clr_i && bus.cs_i && !r_ack;
  assign w_bus_wr   = w_bus_req && bus.wr_i;
  assign stp_rdy_o  = (r_state == S_IDLE) && !bus.cs_i && !clr_i;
  assign w_mark_acc = stp_i && stp_rdy_o;

  assign w_old_card = r_cm[r_cidx];
  assign w_old_bit  = w_old_card[r_cb];

  assign bus.ack_o   = r_ack;
  assign bus.dat_o   = r_dat;
  assign clr_busy_o  = (r_state == S_CLR);
  assign clr_done_o  = r_done;
  assign dirty_cnt_o = r_dirty;

  // Single write port per array, shared by bus writes, marks and the sweep.
  always_comb begin
    w_cm_we = 1'b0;
    w_cm_wa = w_bus_cidx;
    w_cm_wd = bus.dat_i;
    w_sm_we = 1'b0;
    w_sm_wa = w_bus_sidx;
    w_sm_wd = bus.dat_i;
    case (r_state)
      S_IDLE: begin
        w_cm_we = w_bus_wr && !w_bus_sm;
        w_sm_we = w_bus_wr && w_bus_sm;
      end
      S_MARK: begin
        w_cm_we = 1'b1;
        w_cm_wa = r_cidx;
        w_cm_wd = w_old_card | (DW'(1) << r_cb);
        w_sm_we = 1'b1;
        w_sm_wa = r_sidx;
        w_sm_wd = r_sm[r_sidx] | (DW'(1) << r_sb);
      end
      S_CLR: begin
        w_cm_we = 1'b1;
        w_cm_wa = r_cnt;
        w_cm_wd = '0;
        w_sm_we = (r_cnt[C_CIW-1:C_SIW] == '0);
        w_sm_wa = r_cnt[C_SIW-1:0];
        w_sm_wd = '0;
      end
      default: ;
    endcase
  end

  // Array writes; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_cm_we) r_cm[w_cm_wa] <= w_cm_wd;
    if (w_sm_we) r_sm[w_sm_wa] <= w_sm_wd;
  end

  // Control FSM: arbitration, bus read return, mark counting and sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_done   <= 1'b0;
      r_dirty  <= '0;
      r_cnt    <= '0;
      r_cidx   <= '0;
      r_sidx   <= '0;
      r_cb     <= '0;
      r_sb     <= '0;
      r_bus_sm <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clr_i) begin
            r_cnt   <= '0;
            r_state <= S_CLR;
          end else if (w_bus_req) begin
            if (bus.wr_i) begin
              r_ack <= 1'b1;
            end else begin
              r_bus_sm <= w_bus_sm;
              r_cidx   <= w_bus_cidx;
              r_sidx   <= w_bus_sidx;
              r_state  <= S_RD;
            end
          end else if (w_mark_acc) begin
            r_cidx  <= w_mk_cidx;
            r_sidx  <= w_mk_sidx;
            r_cb    <= w_mk_cb;
            r_sb    <= w_mk_sb;
            r_state <= S_MARK;
          end
        end
        S_RD: begin
          r_dat   <= r_bus_sm ? r_sm[r_sidx] : r_cm[r_cidx];
          r_ack   <= 1'b1;
          r_state <= S_IDLE;
        end
        S_MARK: begin
          if (!w_old_bit && (r_dirty != '1)) r_dirty <= r_dirty + 32'd1;
          r_state <= S_IDLE;
        end
        S_CLR: begin
          r_cnt <= r_cnt + C_CIW'(1);
          if (r_cnt == '1) begin
            r_dirty <= '0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_card_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_card_table
// Description : Directed self-checking bench for card_table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card_table;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [5:0]  mapno;
  logic        stp;
  logic [31:0] stp_adr;
  logic        stp_rdy;
  logic        clr;
  logic        clr_busy;
  logic        clr_done;
  logic [31:0] dirty_cnt;

  int n_total = 0;
  int n_bad   = 0;

  card_table_if #(.DW(64)) bus_if ();

  card_table #(.DW(64), .MAPW(6), .AW(8), .CS(5)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bus         (bus_if.slave),
    .mapno_i     (mapno),
    .stp_i       (stp),
    .stp_adr_i   (stp_adr),
    .stp_rdy_o   (stp_rdy),
    .clr_i       (clr),
    .clr_busy_o  (clr_busy),
    .clr_done_o  (clr_done),
    .dirty_cnt_o (dirty_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] m, input logic [31:0] adr, input logic [63:0] d);
    mapno = m; bus_if.adr_i = adr; bus_if.dat_i = d;
    bus_if.wr_i = 1'b1; bus_if.cs_i = 1'b1;
    step();
    check_eq("wr_ack", {63'd0, bus_if.ack_o}, 64'd1);
    step();
    check_eq("wr_ack_pulse", {63'd0, bus_if.ack_o}, 64'd0);
    bus_if.cs_i = 1'b0; bus_if.wr_i = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [5:0] m, input logic [31:0] adr,
                          input logic [63:0] exp);
    mapno = m; bus_if.adr_i = adr; bus_if.wr_i = 1'b0; bus_if.cs_i = 1'b1;
    step();
    check_eq({tag, "_ack_early"}, {63'd0, bus_if.ack_o}, 64'd0);
    step();
    check_eq({tag, "_ack"}, {63'd0, bus_if.ack_o}, 64'd1);
    check_eq(tag, bus_if.dat_o, exp);
    step();
    bus_if.cs_i = 1'b0;
  endtask

  task automatic do_mark(input logic [5:0] m, input logic [31:0] adr);
    int w;
    w = 0;
    while (!stp_rdy && w < 10) begin step(); w++; end
    check_eq("mark_rdy_wait", {63'd0, stp_rdy}, 64'd1);
    mapno = m; stp_adr = adr; stp = 1'b1;
    step();
    stp = 1'b0;
    check_eq("mark_busy", {63'd0, stp_rdy}, 64'd0);
    step();
    check_eq("mark_rdy_again", {63'd0, stp_rdy}, 64'd1);
  endtask

  task automatic do_sweep(input bit with_cs);
    int n;
    int ack_seen;
    int rdy_seen;
    int w;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0; ack_seen = 0; rdy_seen = 0;
    while (clr_busy && n < 20000) begin
      if (with_cs && n == 100) begin
        mapno = 6'd0; bus_if.adr_i = 32'h0; bus_if.wr_i = 1'b0; bus_if.cs_i = 1'b1;
      end
      if (bus_if.ack_o) ack_seen++;
      if (stp_rdy) rdy_seen++;
      n++;
      step();
    end
    check_eq("sweep_cycles", 64'(n), 64'd16384);
    check_eq("sweep_done", {63'd0, clr_done}, 64'd1);
    check_eq("sweep_ack_stall", 64'(ack_seen), 64'd0);
    check_eq("sweep_rdy_stall", 64'(rdy_seen), 64'd0);
    check_eq("sweep_dirty", {32'd0, dirty_cnt}, 64'd0);
    if (with_cs) begin
      w = 0;
      while (!bus_if.ack_o && w < 6) begin step(); w++; end
      check_eq("post_sweep_ack", {63'd0, bus_if.ack_o}, 64'd1);
      check_eq("post_sweep_rd", bus_if.dat_o, 64'd0);
      step();
      bus_if.cs_i = 1'b0;
    end else begin
      step();
      check_eq("done_pulse", {63'd0, clr_done}, 64'd0);
    end
  endtask

  initial begin
    rst_ni = 1'b0; mapno = '0; stp = 1'b0; stp_adr = '0; clr = 1'b0;
    bus_if.cs_i = 1'b0; bus_if.wr_i = 1'b0; bus_if.adr_i = '0; bus_if.dat_i = '0;
    repeat (3) step();
    check_eq("rst_ack", {63'd0, bus_if.ack_o}, 64'd0);
    check_eq("rst_dat", bus_if.dat_o, 64'd0);
    check_eq("rst_busy", {63'd0, clr_busy}, 64'd0);
    check_eq("rst_done", {63'd0, clr_done}, 64'd0);
    check_eq("rst_dirty", {32'd0, dirty_cnt}, 64'd0);
    check_eq("rst_rdy", {63'd0, stp_rdy}, 64'd1);
    rst_ni = 1'b1;
    step();

    do_sweep(1'b0);

    // Mark decode: card idx 0x25 bit 34, summary idx 0 bit 37.
    do_mark(6'd3, 32'h0001_2C40);
    check_eq("dirty_first", {32'd0, dirty_cnt}, 64'd1);
    bus_read("card_rd", 6'd3, 32'h128, 64'h0000_0004_0000_0000);
    bus_read("sum_rd", 6'd3, 32'h800, 64'h0000_0020_0000_0000);

    // Remarking an already dirty card changes nothing.
    do_mark(6'd3, 32'h0001_2C40);
    check_eq("dirty_repeat", {32'd0, dirty_cnt}, 64'd1);
    bus_read("card_rd2", 6'd3, 32'h128, 64'h0000_0004_0000_0000);
    bus_read("sum_rd2", 6'd3, 32'h800, 64'h0000_0020_0000_0000);

    // Bus write then read back.
    bus_write(6'd7, 32'h010, 64'hDEAD_BEEF_0123_4567);
    bus_read("wr_rd", 6'd7, 32'h010, 64'hDEAD_BEEF_0123_4567);

    // Contention: read wins, mark (card bit 35) follows.
    mapno = 6'd3; bus_if.adr_i = 32'h128; bus_if.wr_i = 1'b0; bus_if.cs_i = 1'b1;
    stp_adr = 32'h0001_2C60; stp = 1'b1;
    #1;
    check_eq("cont_rdy_idle", {63'd0, stp_rdy}, 64'd0);
    step();
    check_eq("cont_rdy_rd", {63'd0, stp_rdy}, 64'd0);
    step();
    check_eq("cont_ack", {63'd0, bus_if.ack_o}, 64'd1);
    check_eq("cont_rd", bus_if.dat_o, 64'h0000_0004_0000_0000);
    check_eq("cont_rdy_ack", {63'd0, stp_rdy}, 64'd0);
    step();
    bus_if.cs_i = 1'b0;
    #1;
    check_eq("cont_rdy_free", {63'd0, stp_rdy}, 64'd1);
    step();
    stp = 1'b0;
    check_eq("cont_mark_busy", {63'd0, stp_rdy}, 64'd0);
    step();
    check_eq("cont_dirty", {32'd0, dirty_cnt}, 64'd2);
    bus_read("cont_card", 6'd3, 32'h128, 64'h0000_000C_0000_0000);
    bus_read("cont_sum", 6'd3, 32'h800, 64'h0000_0020_0000_0000);

    // Corner maps: map 0 first card bit, map 63 last card/summary bit.
    do_mark(6'd0, 32'h0000_0000);
    do_mark(6'd63, 32'h0007_FFE0);
    check_eq("dirty_corner", {32'd0, dirty_cnt}, 64'd4);
    bus_read("map0_card", 6'd0, 32'h000, 64'h0000_0000_0000_0001);
    bus_read("map63_card", 6'd63, 32'h7F8, 64'h8000_0000_0000_0000);
    bus_read("map63_sum", 6'd63, 32'h818, 64'h8000_0000_0000_0000);

    do_sweep(1'b1);
    bus_read("clr_map63_card", 6'd63, 32'h7F8, 64'd0);
    bus_read("clr_map63_sum", 6'd63, 32'h818, 64'd0);
    bus_read("clr_map3_card", 6'd3, 32'h128, 64'd0);
    bus_read("clr_map3_sum", 6'd3, 32'h800, 64'd0);
    bus_read("clr_map7", 6'd7, 32'h010, 64'd0);
    check_eq("clr_dirty", {32'd0, dirty_cnt}, 64'd0);

    // Reset in the middle of a sweep.
    do_mark(6'd5, 32'h0000_0040);
    check_eq("pre_rst_dirty", {32'd0, dirty_cnt}, 64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (50) step();
    check_eq("mid_busy", {63'd0, clr_busy}, 64'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_ack", {63'd0, bus_if.ack_o}, 64'd0);
    check_eq("mid_rst_busy", {63'd0, clr_busy}, 64'd0);
    check_eq("mid_rst_dirty", {32'd0, dirty_cnt}, 64'd0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    check_eq("post_rst_rdy", {63'd0, stp_rdy}, 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
